// File: rtl/sfp_pkg.sv
// Shared widths for the sfp datapath and its psum output FIFO.
// Both sides import this so partial-sum widths and pointer sizes agree.
package sfp_pkg;

    localparam int unsigned PSUM_BW     = 16;
    localparam int unsigned BW          = 4;
    localparam int unsigned OFIFO_DEPTH = 8;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ofifo_mem.sv
// Storage array for psum_ofifo: one write port, one registered read port.
// The array itself is never reset; only the read-data register is.
module ofifo_mem
    import sfp_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned depth   = OFIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [clog2(depth)-1:0]       waddr,
    input  logic signed [psum_bw-1:0]     wdata,
    input  logic                          re,
    input  logic [clog2(depth)-1:0]       raddr,
    output logic signed [psum_bw-1:0]     rdata
);

    logic signed [psum_bw-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read samples the pre-write contents, so a full FIFO doing rd+wr returns the oldest word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO for one MAC-array column feeding sfp: pointers, occupancy,
// level flags and sticky overflow/underflow around an ofifo_mem array.
module psum_ofifo
    import sfp_pkg::*;
#(
    parameter int unsigned psum_bw  = PSUM_BW,
    parameter int unsigned depth    = OFIFO_DEPTH,
    parameter int unsigned af_level = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr,
    input  logic signed [psum_bw-1:0]     in,
    input  logic                          rd,
    output logic signed [psum_bw-1:0]     out,
    output logic                          o_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic [clog2(depth):0]         count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = clog2(depth);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_ok;
    logic          wr_ok;

    always_comb begin
        full        = (count == PW'(depth));
        empty       = (count == '0);
        almost_full = (count >= PW'(af_level));
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    always_comb begin
        rd_ok = rd && !empty;
        wr_ok = wr && (!full || rd_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
            o_valid <= rd_ok;
            if (wr && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    ofifo_mem #(
        .psum_bw (psum_bw),
        .depth   (depth)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in),
        .re    (rd_ok),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out)
    );

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: directed scenarios plus random traffic, each cycle
// compared against a queue-based reference of the FIFO's behaviour.
module tb_psum_ofifo;

    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic               clk;
    logic               reset;
    logic               wr;
    logic               rd;
    logic signed [15:0] din;
    logic signed [15:0] dout;
    logic               o_valid;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic [3:0]         count;
    logic               overflow;
    logic               underflow;

    psum_ofifo #(
        .psum_bw  (16),
        .depth    (DEPTH),
        .af_level (AF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .in          (din),
        .rd          (rd),
        .out         (dout),
        .o_valid     (o_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] q [$];
    logic signed [15:0] m_out;
    logic               m_valid;
    logic               m_ov;
    logic               m_un;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},         dout,        m_out);
        chk({tag, ".o_valid"},     o_valid,     m_valid);
        chk({tag, ".count"},       count,       q.size());
        chk({tag, ".full"},        full,        q.size() == DEPTH);
        chk({tag, ".empty"},       empty,       q.size() == 0);
        chk({tag, ".almost_full"}, almost_full, q.size() >= AF);
        chk({tag, ".overflow"},    overflow,    m_ov);
        chk({tag, ".underflow"},   underflow,   m_un);
    endtask

    // One clock of traffic: drive, advance the reference, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic w, input logic r, input logic signed [15:0] d);
        bit was_empty, was_full, rok, wok;
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        rok = r && !was_empty;
        wok = w && (!was_full || rok);
        if (rok) begin
            m_out   = q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wok) q.push_back(d);
        if (w && !wok) m_ov = 1'b1;
        if (r && was_empty) m_un = 1'b1;
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_all("reset");

        // 1: three writes then three reads
        step("t1_wr", 1, 0, 16'sd3);
        step("t1_wr", 1, 0, -16'sd5);
        step("t1_wr", 1, 0, 16'sd7);
        for (int i = 0; i < 3; i++) step("t1_rd", 0, 1, '0);
        step("t1_idle", 0, 0, '0);

        // 2: fill, overflow, drain
        for (int i = 1; i <= 8; i++) step("t2_fill", 1, 0, 16'(i));
        step("t2_ovf", 1, 0, 16'sd9);
        for (int i = 0; i < 8; i++) step("t2_drain", 0, 1, '0);

        // 3: underflow and rd+wr on empty
        reset = 1'b1; #1 reset = 1'b0; model_reset();
        step("t3_rd_empty", 0, 1, '0);
        step("t3_rdwr_empty", 1, 1, 16'sd55);
        step("t3_drain", 0, 1, '0);

        // 4: rd+wr when full
        for (int i = 0; i < 8; i++) step("t4_fill", 1, 0, 16'(200 + i));
        step("t4_rdwr_full", 1, 1, 16'sd100);
        for (int i = 0; i < 7; i++) step("t4_drain", 0, 1, '0);
        step("t4_eighth", 0, 1, '0);
        chk("t4_eighth_is_100", dout, 32'd100);

        // 5: streaming at count=4 across two pointer wraps
        for (int i = 0; i < 4; i++) step("t5_prime", 1, 0, 16'(300 + i));
        for (int i = 0; i < 20; i++) step("t5_stream", 1, 1, 16'(400 + i));
        for (int i = 0; i < 4; i++) step("t5_drain", 0, 1, '0);

        // 6: async reset mid-cycle with count=5
        for (int i = 0; i < 5; i++) step("t6_fill", 1, 0, 16'($urandom));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_reset");
        @(negedge clk) reset = 1'b0;
        step("t6_wr_min", 1, 0, -16'sd32768);
        step("t6_rd_min", 0, 1, '0);
        chk("t6_min_value", dout, 32'hFFFF8000);

        // random traffic: write-heavy phase then read-heavy phase
        for (int i = 0; i < 400; i++) begin
            logic w, r;
            if (i < 200) begin
                w = ($urandom_range(0, 99) < 70);
                r = ($urandom_range(0, 99) < 40);
            end else begin
                w = ($urandom_range(0, 99) < 35);
                r = ($urandom_range(0, 99) < 70);
            end
            step("rand", w, r, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
